ocimem_debug_arbiter: RTL and testbench
=======================================

Name: ocimem_debug_arbiter

Overview:
Shares the single-port 256x32 on-chip debug RAM (OCI memory) between two requesters:
- the JTAG debug path, via the sysclk-side take_action/take_no_action strobes and jdo;
- the CPU debug Avalon slave.
Sequences each access (address, write, read capture), auto-increments the JTAG address, loads MonDReg for JTAG reads, and flags command overruns. Sits between the debug-slave sysclk logic and the OCI RAM.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, RAM/Avalon/MonDReg data width
JDO_W, 38, jdo width

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address from jdo; optional read
take_action_ocimem_b  in  1  1-cycle strobe: JTAG write of jdo data at JTAG address
take_no_action_ocimem_a  in  1  1-cycle strobe: JTAG read at JTAG address
jdo  in  JDO_W  JTAG data out; stable during its strobe cycle
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request; held until accepted
avs_write  in  1  CPU write request; held until accepted
avs_writedata  in  DATA_W  CPU write data
avs_waitrequest  out  1  = (avs_read|avs_write) & ~cpu_accept
avs_readdata  out  DATA_W  registered CPU read data
avs_readdatavalid  out  1  1-cycle pulse with avs_readdata
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_wrdata  out  DATA_W  RAM write data
ram_rddata  in  DATA_W  RAM read data, valid 1 cycle after address
MonDReg  out  DATA_W  last JTAG read data
jtag_busy  out  1  JTAG command pending or in flight
jtag_overrun  out  1  sticky: JTAG command dropped

Behaviour:
Interface: one clock clk; reset is synchronous and active-high.

Reset values:
- All outputs 0 except avs_waitrequest (combinational).
- FSM = IDLE; jaddr = 0; last_grant = CPU.

JTAG command decode (jdo field positions are package constants):
- ocimem_a: jaddr <= jdo[ADDR_W+1:2]. If jdo[25]=1, queue read. If jdo[35]=1, clear jtag_overrun.
- ocimem_b: queue write, data = jdo[34:3].
- no_action_ocimem_a: queue read.
- Queue depth is 1 (j_pend).
- Any strobe while j_pend or a JTAG access is in flight: command dropped, jtag_overrun <= 1. Exception: the ocimem_a address load is dropped too.
- ocimem_a and ocimem_b in the same cycle: ocimem_a wins, ocimem_b dropped, jtag_overrun <= 1.

FSM (IDLE, ACCESS, CAPTURE, RESP):
- IDLE: if j_pend or a CPU request, grant one requester.
  - Tie: requester != last_grant (round-robin); last_grant updated on every grant.
  - CPU granted: cpu_accept = 1 this cycle, so waitrequest = 0 and address/data/command are latched.
  - JTAG granted: j_pend cleared.
  - Go to ACCESS.
- ACCESS: drive ram_addr (latched address). For a write, ram_wren = 1 with ram_wrdata.
  - Write: go to IDLE.
  - Read: go to CAPTURE.
- CAPTURE: sample ram_rddata.
  - JTAG: MonDReg <= ram_rddata, then go to IDLE.
  - CPU: avs_readdata <= ram_rddata, then go to RESP.
- RESP: avs_readdatavalid = 1 for one cycle, then go to IDLE.
- Every JTAG access (read or write) increments jaddr modulo 2^ADDR_W after ACCESS; 0xFF wraps to 0x00.

Latency:
- Write: strobe to ram_wren = 2 cycles (pending, IDLE grant, ACCESS).
- CPU read: accept to readdatavalid = 3 cycles.

jtag_busy = j_pend | (FSM != IDLE & grant == JTAG).

Reset mid-operation: the in-flight access is abandoned, no readdatavalid is produced, the pending command is lost, and no partial write occurs after reset is sampled.

ram_wren is never asserted outside ACCESS.

Optional Feature:
OCIMEM_CPU_WP_EN.
- Defined: adds input debugack (1) and output wp_err (1, sticky, cleared by reset). A CPU write accepted while debugack=0 completes the handshake but ram_wren is held 0, and wp_err <= 1. JTAG writes are never blocked.
- Undefined: neither port exists, and all CPU writes reach the RAM.

Decomposition:
Package ocimem_arb_pkg holds:
- state enum;
- grant enum {GNT_JTAG, GNT_CPU};
- jdo field constants: JDO_ADDR_LSB = 2, JDO_RDEN_BIT = 25, JDO_WDATA_LSB = 3, JDO_CLR_OVR_BIT = 35.

One sub-module, ocimem_rr_arb2: 2-requester round-robin with last_grant register. The FSM and datapath stay in the top module.

Test Plan:
- ocimem_a with jdo address=0x10 and jdo[25]=0, then ocimem_b data=0xDEADBEEF, then ocimem_b data=0x12345678 → RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678, jaddr=0x12.
- ocimem_a address=0xFF with read, then no_action_ocimem_a → MonDReg=RAM[0xFF], then MonDReg=RAM[0x00]; jaddr wraps to 0x01.
- CPU read 0x20 and JTAG read pending in the same cycle after reset → JTAG granted first, CPU waitrequest held 1 until the next IDLE; readdatavalid 3 cycles after accept with RAM[0x20].
- Two JTAG strobes in consecutive cycles → second dropped, jtag_overrun=1; ocimem_a with jdo[35]=1 → jtag_overrun=0.
- Reset asserted during CPU read CAPTURE → no avs_readdatavalid; FSM returns to IDLE; all outputs at reset values.
- With OCIMEM_CPU_WP_EN defined, debugack=0: CPU write 0x5A to 0x30 → waitrequest drops, ram_wren stays 0, wp_err=1, RAM[0x30] unchanged.

Source files
------------

// File: rtl/ocimem_arb_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter.
// Imported by ocimem_rr_arb2 and ocimem_debug_arbiter.
package ocimem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    typedef enum logic {
        GNT_JTAG = 1'b0,
        GNT_CPU  = 1'b1
    } grant_e;

    localparam int JDO_ADDR_LSB    = 2;
    localparam int JDO_RDEN_BIT    = 25;
    localparam int JDO_WDATA_LSB   = 3;
    localparam int JDO_CLR_OVR_BIT = 35;

endpackage

// File: rtl/ocimem_rr_arb2.sv
// Two-requester round-robin arbiter (JTAG vs CPU) with last-grant memory.
// Ports: clk, reset, en (grant allowed), req_jtag, req_cpu -> gnt_valid, gnt.
module ocimem_rr_arb2
    import ocimem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   req_jtag,
    input  logic   req_cpu,
    output logic   gnt_valid,
    output grant_e gnt
);

    grant_e last_grant;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_valid = en & (req_jtag | req_cpu);
        gnt       = GNT_JTAG;
        if (req_jtag && req_cpu) begin
            if (last_grant == GNT_JTAG)
                gnt = GNT_CPU;
        end else if (req_cpu) begin
            gnt = GNT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= GNT_CPU;
        else if (gnt_valid)
            last_grant <= gnt;
    end

endmodule

// File: rtl/ocimem_debug_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG commands and the CPU
// debug Avalon slave: grant, ACCESS, CAPTURE, optional Avalon response.
// Ports: clk/reset (sync, active-high); JTAG strobes + jdo; Avalon slave
// avs_*; RAM ram_addr/ram_wren/ram_wrdata/ram_rddata; MonDReg,
// jtag_busy, jtag_overrun. Optional OCIMEM_CPU_WP_EN adds debugack/wp_err
// and blocks CPU RAM writes while the CPU is not in debug.
module ocimem_debug_arbiter
    import ocimem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int JDO_W  = 38
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
`ifdef OCIMEM_CPU_WP_EN
    input  logic              debugack,
    output logic              wp_err,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wrdata,
    input  logic [DATA_W-1:0] ram_rddata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    state_e            state;
    grant_e            cur_gnt;
    grant_e            gnt;
    logic              gnt_valid;
    logic              acc_wr;

    logic              j_pend;
    logic              j_wr;
    logic [DATA_W-1:0] j_wdata;
    logic [ADDR_W-1:0] jaddr;

    logic              cpu_req;
    logic              cpu_accept;
    logic              jtag_grant;
    logic              j_inflight;
    logic              j_block;
    logic              a_ok;
    logic              b_ok;
    logic              na_ok;
    logic              drop;
    logic              jaddr_inc;
    logic              cpu_wr_ok;

    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_OVR_BIT+1],
                          jdo[JDO_ADDR_LSB-1:0]};

    assign cpu_req    = avs_read | avs_write;

    ocimem_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (state == ST_IDLE),
        .req_jtag  (j_pend),
        .req_cpu   (cpu_req),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign cpu_accept = gnt_valid & (gnt == GNT_CPU);
    assign jtag_grant = gnt_valid & (gnt == GNT_JTAG);

    assign avs_waitrequest = cpu_req & ~cpu_accept;

    assign j_inflight = (state != ST_IDLE) & (cur_gnt == GNT_JTAG);
    assign j_block    = j_pend | j_inflight;
    assign jtag_busy  = j_block;
    assign jaddr_inc  = (state == ST_ACCESS) & (cur_gnt == GNT_JTAG);

`ifdef OCIMEM_CPU_WP_EN
    assign cpu_wr_ok = debugack;

    always_ff @(posedge clk) begin
        if (reset)
            wp_err <= 1'b0;
        else if (cpu_accept && avs_write && !debugack)
            wp_err <= 1'b1;
    end
`else
    assign cpu_wr_ok = 1'b1;
`endif

    // Strobe priority a > b > no_action; losers and anything arriving
    // while a command is queued or in flight are dropped and flagged.
    assign a_ok  = take_action_ocimem_a & ~j_block;
    assign b_ok  = take_action_ocimem_b & ~take_action_ocimem_a & ~j_block;
    assign na_ok = take_no_action_ocimem_a & ~take_action_ocimem_a
                   & ~take_action_ocimem_b & ~j_block;

    assign drop = ((take_action_ocimem_a | take_action_ocimem_b
                    | take_no_action_ocimem_a) & j_block)
                | (take_action_ocimem_a
                   & (take_action_ocimem_b | take_no_action_ocimem_a))
                | (take_action_ocimem_b & take_no_action_ocimem_a);

    always_ff @(posedge clk) begin
        if (reset) begin
            jaddr        <= '0;
            j_pend       <= 1'b0;
            j_wr         <= 1'b0;
            j_wdata      <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (jaddr_inc)
                jaddr <= jaddr + ADDR_W'(1);
            if (jtag_grant)
                j_pend <= 1'b0;
            if (a_ok) begin
                jaddr <= jdo_addr;
                if (jdo[JDO_RDEN_BIT]) begin
                    j_pend <= 1'b1;
                    j_wr   <= 1'b0;
                end
            end
            if (b_ok) begin
                j_pend  <= 1'b1;
                j_wr    <= 1'b1;
                j_wdata <= jdo_wdata;
            end
            if (na_ok) begin
                j_pend <= 1'b1;
                j_wr   <= 1'b0;
            end
            if (drop)
                jtag_overrun <= 1'b1;
            else if (a_ok && jdo[JDO_CLR_OVR_BIT])
                jtag_overrun <= 1'b0;
        end
    end

    // RAM controls are registered on the grant edge so they are valid
    // for exactly the ACCESS cycle; ram_wren is dropped leaving ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            cur_gnt           <= GNT_CPU;
            acc_wr            <= 1'b0;
            ram_addr          <= '0;
            ram_wren          <= 1'b0;
            ram_wrdata        <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            MonDReg           <= '0;
        end else begin
            avs_readdatavalid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        cur_gnt <= gnt;
                        state   <= ST_ACCESS;
                        if (gnt == GNT_CPU) begin
                            ram_addr   <= avs_address;
                            acc_wr     <= avs_write;
                            ram_wrdata <= avs_writedata;
                            ram_wren   <= avs_write & cpu_wr_ok;
                        end else begin
                            ram_addr   <= jaddr;
                            acc_wr     <= j_wr;
                            ram_wrdata <= j_wdata;
                            ram_wren   <= j_wr;
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_wren <= 1'b0;
                    state    <= acc_wr ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (cur_gnt == GNT_JTAG) begin
                        MonDReg <= ram_rddata;
                        state   <= ST_IDLE;
                    end else begin
                        avs_readdata      <= ram_rddata;
                        avs_readdatavalid <= 1'b1;
                        state             <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ocimem_debug_arbiter.sv
// Self-checking bench for ocimem_debug_arbiter with a behavioural RAM,
// a CPU read scoreboard, a CPU op vector table and JTAG corner sequences.
module tb_ocimem_debug_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wrdata;
    logic [31:0] ram_rddata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
`ifdef OCIMEM_CPU_WP_EN
    logic        debugack;
    logic        wp_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ocimem_debug_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_waitrequest         (avs_waitrequest),
        .avs_readdata            (avs_readdata),
        .avs_readdatavalid       (avs_readdatavalid),
`ifdef OCIMEM_CPU_WP_EN
        .debugack                (debugack),
        .wp_err                  (wp_err),
`endif
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wrdata              (ram_wrdata),
        .ram_rddata              (ram_rddata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    // Behavioural 256x32 RAM, read data one cycle after the address.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wrdata;
        ram_rddata <= mem[ram_addr];
    end

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA5, b, ~b, b ^ 8'h5A};
    endfunction

    function automatic logic [37:0] jdo_a(input logic [7:0] a,
                                          input logic rd,
                                          input logic clr);
        logic [37:0] v;
        v = '0;
        v[9:2] = a;
        v[25] = rd;
        v[35] = clr;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        if (!reset && avs_readdatavalid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv got=%h want=none",
                         avs_readdata);
            end else begin
                e = sbq.pop_front();
                chk("cpu_rdata", avs_readdata, e.data);
                chk("cpu_rd_lat", 32'(cyc - e.acc), 32'd3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a
    task automatic jcmd(input int kind, input logic [37:0] d);
        jdo = d;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_jidle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (jtag_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (jtag_busy) begin
            errors++;
            $display("FAIL %s busy_timeout got=1 want=0", nm);
        end
        tick();
    endtask

    task automatic jread(input string nm, input logic [31:0] exp);
        jcmd(2, '0);
        wait_jidle(nm);
        chk(nm, MonDReg, exp);
    endtask

    task automatic cpu_op(input bit wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        int n;
        avs_address = a;
        avs_writedata = d;
        avs_read = !wr;
        avs_write = wr;
        n = 0;
        @(negedge clk);
        while (avs_waitrequest && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (avs_waitrequest) begin
            errors++;
            $display("FAIL cpu_accept_timeout got=1 want=0");
        end else if (!wr) begin
            e.data = exp;
            e.acc = cyc;
            sbq.push_back(e);
        end
        tick();
        avs_read = 1'b0;
        avs_write = 1'b0;
        repeat (4) tick();
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        tbl[0] = '{1'b1, 8'h40, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[1] = '{1'b0, 8'h40, 32'h0, 32'hCAFEF00D};
        tbl[2] = '{1'b0, 8'h10, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 8'h11, 32'h0, 32'h12345678};
        tbl[4] = '{1'b1, 8'hFF, 32'h0BADC0DE, 32'h0BADC0DE};
        tbl[5] = '{1'b0, 8'hFF, 32'h0, 32'h0BADC0DE};
        tbl[6] = '{1'b0, 8'h7E, 32'h0, pat(8'h7E)};
        tbl[7] = '{1'b0, 8'h00, 32'h0, pat(0)};

        for (int i = 0; i < 256; i++) mem[i] = pat(i);
`ifdef OCIMEM_CPU_WP_EN
        debugack = 1'b1;
`endif
        do_reset();

        @(negedge clk);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_rdv", {31'h0, avs_readdatavalid}, 32'h0);
        chk("rst_waitreq", {31'h0, avs_waitrequest}, 32'h0);
        chk("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
        chk("rst_ram_wren", {31'h0, ram_wren}, 32'h0);
        chk("rst_ram_wrdata", ram_wrdata, 32'h0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_busy", {31'h0, jtag_busy}, 32'h0);
        chk("rst_overrun", {31'h0, jtag_overrun}, 32'h0);
        tick();

        // JTAG address load then two writes with auto-increment.
        jcmd(0, jdo_a(8'h10, 1'b0, 1'b0));
        jdo = jdo_b(32'hDEADBEEF);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("wr_lat_c1_wren", {31'h0, ram_wren}, 32'h0);
        @(negedge clk);
        chk("wr_lat_c2_wren", {31'h0, ram_wren}, 32'h1);
        chk("wr_lat_c2_addr", {24'h0, ram_addr}, 32'h10);
        chk("wr_lat_c2_data", ram_wrdata, 32'hDEADBEEF);
        tick();
        wait_jidle("jwr1");
        jcmd(1, jdo_b(32'h12345678));
        wait_jidle("jwr2");
        tick();
        chk("mem_10", mem[8'h10], 32'hDEADBEEF);
        chk("mem_11", mem[8'h11], 32'h12345678);
        jread("jaddr_12", pat(8'h12));

        // Address load with read at 0xFF, then wrap.
        jcmd(0, jdo_a(8'hFF, 1'b1, 1'b0));
        wait_jidle("rd_ff");
        chk("mon_ff", MonDReg, pat(8'hFF));
        jread("mon_00", pat(8'h00));
        jread("mon_01", pat(8'h01));

        // Tie after reset: JTAG wins, CPU waits for next IDLE.
        do_reset();
        jcmd(2, '0);
        avs_address = 8'h20;
        avs_read = 1'b1;
        @(negedge clk);
        chk("tie_wait_c1", {31'h0, avs_waitrequest}, 32'h1);
        chk("tie_busy_c1", {31'h0, jtag_busy}, 32'h1);
        @(negedge clk);
        chk("tie_wait_c2", {31'h0, avs_waitrequest}, 32'h1);
        @(negedge clk);
        chk("tie_wait_c3", {31'h0, avs_waitrequest}, 32'h1);
        @(negedge clk);
        chk("tie_wait_c4", {31'h0, avs_waitrequest}, 32'h0);
        sbq.push_back('{pat(8'h20), cyc});
        tick();
        avs_read = 1'b0;
        repeat (5) tick();
        chk("tie_mon", MonDReg, pat(8'h00));

        // Overrun: back-to-back strobes, then clear.
        jcmd(2, '0);
        jcmd(2, '0);
        wait_jidle("ovr");
        chk("ovr_set", {31'h0, jtag_overrun}, 32'h1);
        chk("ovr_mon", MonDReg, pat(8'h01));
        jread("ovr_no_inc", pat(8'h02));
        jcmd(0, jdo_a(8'h05, 1'b0, 1'b1));
        @(negedge clk);
        chk("ovr_clr", {31'h0, jtag_overrun}, 32'h0);
        tick();
        jdo = jdo_a(8'h05, 1'b0, 1'b0);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        chk("ab_ovr", {31'h0, jtag_overrun}, 32'h1);
        chk("ab_busy", {31'h0, jtag_busy}, 32'h0);
        tick();
        jcmd(0, jdo_a(8'h05, 1'b0, 1'b1));
        @(negedge clk);
        chk("ab_clr", {31'h0, jtag_overrun}, 32'h0);
        tick();
        jread("ab_addr", pat(8'h05));

        // CPU vector table.
        for (int i = 0; i < 8; i++) begin
            cpu_op(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp);
            if (tbl[i].wr)
                chk("tbl_mem", mem[tbl[i].addr], tbl[i].exp);
        end

        // Reset during CPU read CAPTURE.
        avs_address = 8'h22;
        avs_read = 1'b1;
        @(negedge clk);
        chk("rst_mid_acc", {31'h0, avs_waitrequest}, 32'h0);
        tick();
        avs_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdv", {31'h0, avs_readdatavalid}, 32'h0);
        chk("rst_mid_rdata", avs_readdata, 32'h0);
        chk("rst_mid_mon", MonDReg, 32'h0);
        chk("rst_mid_wren", {31'h0, ram_wren}, 32'h0);
        chk("rst_mid_busy", {31'h0, jtag_busy}, 32'h0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (avs_readdatavalid) seen++;
        end
        chk("rst_mid_no_rdv", 32'(seen), 32'h0);
        tick();
        cpu_op(1'b0, 8'h40, 32'h0, 32'hCAFEF00D);

`ifdef OCIMEM_CPU_WP_EN
        debugack = 1'b0;
        avs_address = 8'h30;
        avs_writedata = 32'h5A;
        avs_write = 1'b1;
        @(negedge clk);
        chk("wp_accept", {31'h0, avs_waitrequest}, 32'h0);
        tick();
        avs_write = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_wren) seen++;
        end
        chk("wp_no_wren", 32'(seen), 32'h0);
        chk("wp_err", {31'h0, wp_err}, 32'h1);
        chk("wp_mem", mem[8'h30], pat(8'h30));
        debugack = 1'b1;
        tick();
`endif

        repeat (6) tick();
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
